btn_debounce: RTL

Button conditioning stage that sits directly upstream of the LED counter: it takes a raw, asynchronous, bouncing push-button input (e.g. BTND) and produces a clean, debounced level for the counter's direction control. It also produces single-cycle rise and fall pulses, plus an optional auto-repeat pulse while the button is held. The block synchronises the input, qualifies each transition with a stability counter, and tracks button state in a four-state FSM.

---
 rtl/btn_pkg.sv | 20 ++
 rtl/sync_ff.sv | 32 +++
 rtl/btn_debounce.sv | 136 +++++++++++++
 3 files changed

// File: rtl/btn_pkg.sv
// Shared button-conditioning constants and FSM state encoding, so every
// button consumer on the board debounces with the same timing.
package btn_pkg;

    localparam int unsigned BTN_STABLE_CYCLES = 1000000;
    localparam int unsigned BTN_SYNC_STAGES   = 2;

    // bit 1 of the encoding is the level the FSM is currently committed to
    typedef enum logic [1:0] {
        IDLE_LO = 2'b00,
        WAIT_HI = 2'b01,
        IDLE_HI = 2'b11,
        WAIT_LO = 2'b10
    } btn_state_e;

    function automatic int unsigned btn_max(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/sync_ff.sv
// STAGES-deep flop chain bringing an asynchronous board input into the clk domain.
module sync_ff #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain_q;
    logic [STAGES-1:0] chain_d;

    if (STAGES < 2) begin : g_bad_stages
        $error("sync_ff: STAGES must be at least 2");
    end

    always_comb begin
        chain_d = {chain_q[STAGES-2:0], d};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chain_q <= '0;
        end else begin
            chain_q <= chain_d;
        end
    end

    assign q = chain_q[STAGES-1];

endmodule

// File: rtl/btn_debounce.sv
// Push-button debouncer: synchronise, qualify each edge, emit level and edge pulses.
// Auto-repeat pulses are built only when BTN_DEBOUNCE_REPEAT_EN is defined.
//
// state   | meaning
// IDLE_LO | button settled released, btn_level 0
// WAIT_HI | input high, qualifying a press
// IDLE_HI | button settled pressed, btn_level 1, repeat timer running
// WAIT_LO | input low, qualifying a release, repeat timer frozen
module btn_debounce
    import btn_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES = BTN_STABLE_CYCLES,
    parameter int unsigned SYNC_STAGES   = BTN_SYNC_STAGES,
    parameter int unsigned REPEAT_DELAY  = 50000000,
    parameter int unsigned REPEAT_PERIOD = 10000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_raw,
    output logic btn_level,
    output logic btn_rise,
    output logic btn_fall,
    output logic btn_rpt
);

    localparam int unsigned CNT_W = $clog2(STABLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    if (STABLE_CYCLES < 1) begin : g_bad_stable
        $error("btn_debounce: STABLE_CYCLES must be at least 1");
    end
    if (REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_repeat
        $error("btn_debounce: REPEAT_DELAY and REPEAT_PERIOD must be at least 1");
    end

    logic       btn_sync;
    btn_state_e state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic       level_q, level_d;
    logic       rise_q, rise_d;
    logic       fall_q, fall_d;

    sync_ff #(.STAGES(SYNC_STAGES)) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (btn_raw),
        .q     (btn_sync)
    );

    // Counter compares against the FSM's committed level (state bit 1), which
    // btn_level follows one cycle later so that it and its pulses are registered.
    always_comb begin
        cnt_d   = (btn_sync != state_q[1]) ? cnt_q + 1'b1 : '0;
        state_d = state_q;
        unique case (state_q)
            IDLE_LO: if (btn_sync)  state_d = (cnt_q == CNT_LAST) ? IDLE_HI : WAIT_HI;
            WAIT_HI: if (!btn_sync) state_d = IDLE_LO;
                     else if (cnt_q == CNT_LAST) state_d = IDLE_HI;
            IDLE_HI: if (!btn_sync) state_d = (cnt_q == CNT_LAST) ? IDLE_LO : WAIT_LO;
            WAIT_LO: if (btn_sync)  state_d = IDLE_HI;
                     else if (cnt_q == CNT_LAST) state_d = IDLE_LO;
            default: state_d = IDLE_LO;
        endcase
        level_d = state_q[1];
        rise_d  = state_q[1] & ~level_q;
        fall_d  = ~state_q[1] & level_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE_LO;
            cnt_q   <= '0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

`ifdef BTN_DEBOUNCE_REPEAT_EN
    localparam int unsigned RPT_W = $clog2(btn_max(REPEAT_DELAY, REPEAT_PERIOD) + 1);
    localparam logic [RPT_W-1:0] DELAY_LAST  = RPT_W'(REPEAT_DELAY - 1);
    localparam logic [RPT_W-1:0] PERIOD_LAST = RPT_W'(REPEAT_PERIOD - 1);

    logic [RPT_W-1:0] rpt_cnt_q, rpt_cnt_d;
    logic             first_q, first_d;
    logic             rpt_q, rpt_d;
    logic [RPT_W-1:0] rpt_target;

    // Counts only while staying in IDLE_HI, so a pulse can never land in WAIT_LO.
    always_comb begin
        rpt_cnt_d  = rpt_cnt_q;
        first_d    = first_q;
        rpt_d      = 1'b0;
        rpt_target = first_q ? PERIOD_LAST : DELAY_LAST;
        if (state_q == IDLE_LO || rise_d) begin
            rpt_cnt_d = '0;
            first_d   = 1'b0;
        end else if (state_q == IDLE_HI && state_d == IDLE_HI) begin
            if (rpt_cnt_q == rpt_target) begin
                rpt_cnt_d = '0;
                first_d   = 1'b1;
                rpt_d     = 1'b1;
            end else begin
                rpt_cnt_d = rpt_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rpt_cnt_q <= '0;
            first_q   <= 1'b0;
            rpt_q     <= 1'b0;
        end else begin
            rpt_cnt_q <= rpt_cnt_d;
            first_q   <= first_d;
            rpt_q     <= rpt_d;
        end
    end

    assign btn_rpt = rpt_q;
`else
    assign btn_rpt = 1'b0;
`endif

    assign btn_level = level_q;
    assign btn_rise  = rise_q;
    assign btn_fall  = fall_q;

endmodule
